cache_dm_ctrl: RTL and testbench

CACHE_DM_CTRL -- requirements
Module: cache_dm_ctrl

---
 rtl/cache_dm_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cache_dm_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_dm_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller sitting between a CPU port
// and a block-oriented RAM controller. Lines are held in registers inside this module.

package cache_parameters;
    localparam int ADDR_WIDTH   = 16;
    localparam int WORD_WIDTH   = 32;
    localparam int OFFSET_WIDTH = 2;
    localparam int BLOCK_SIZE   = 4;

    typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

    typedef struct packed {
        logic                  cs;
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        block_t                data;
    } memory_request_t;

    typedef struct packed {
        logic   ack;
        block_t data;
    } memory_response_t;
endpackage

// state      | meaning
// IDLE       | ready for a CPU request; captures it when cpu_req_valid is high
// COMPARE    | tag lookup; a hit completes the request, a miss starts a refill
// WRITE_BACK | dirty victim line is being written to memory
// ALLOCATE   | requested line is being fetched from memory
module cache_dm_ctrl
    import cache_parameters::*;
#(
    parameter int INDEX_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_rw,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [WORD_WIDTH-1:0] cpu_req_data,
    output logic                  cpu_req_ready,
    output logic                  cpu_res_ready,
    output logic [WORD_WIDTH-1:0] cpu_res_data,
    output memory_request_t       mem_req,
    input  memory_response_t      mem_res
);

    localparam int NUM_LINES = 2**INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic                  req_rw_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [WORD_WIDTH-1:0] req_data_q;

    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    logic [TAG_WIDTH-1:0]  tag_q  [NUM_LINES];
    block_t                line_q [NUM_LINES];

    logic [OFFSET_WIDTH-1:0] req_off;
    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    hit;
    logic                    cmp_hit;
    logic                    wr_hit;
    logic                    fill;

    assign req_off = req_addr_q[OFFSET_WIDTH-1:0];
    assign req_idx = req_addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_tag = req_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];

    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign cmp_hit = (state_q == COMPARE) && hit;
    assign wr_hit  = cmp_hit && req_rw_q;
    assign fill    = (state_q == ALLOCATE) && mem_res.ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    state_d = IDLE;
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    state_d = WRITE_BACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (mem_res.ack) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_res.ack) begin
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The captured request stays frozen until the controller is back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_rw_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
        end else if ((state_q == IDLE) && cpu_req_valid) begin
            req_rw_q   <= cpu_req_rw;
            req_addr_q <= cpu_req_addr;
            req_data_q <= cpu_req_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
        end else if (wr_hit) begin
            dirty_q[req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset: a cleared valid bit makes their contents irrelevant,
    // and reset holds the state in IDLE so no fill or write can land during it.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[req_idx]  <= req_tag;
            line_q[req_idx] <= mem_res.data;
        end else if (wr_hit) begin
            line_q[req_idx][req_off] <= req_data_q;
        end
    end

    assign cpu_req_ready = (state_q == IDLE);
    assign cpu_res_ready = cmp_hit;

    always_comb begin
        cpu_res_data = '0;
        if (cmp_hit && !req_rw_q) begin
            cpu_res_data = line_q[req_idx][req_off];
        end
    end

    // cs is a pure state decode, so WRITE_BACK -> ALLOCATE keeps it high without a gap.
    always_comb begin
        mem_req = '0;
        case (state_q)
            WRITE_BACK: begin
                mem_req.cs   = 1'b1;
                mem_req.rw   = 1'b1;
                mem_req.addr = {tag_q[req_idx], req_idx, {OFFSET_WIDTH{1'b0}}};
                mem_req.data = line_q[req_idx];
            end
            ALLOCATE: begin
                mem_req.cs   = 1'b1;
                mem_req.rw   = 1'b0;
                mem_req.addr = {req_tag, req_idx, {OFFSET_WIDTH{1'b0}}};
            end
            default: mem_req = '0;
        endcase
    end

endmodule

// File: tb/tb_cache_dm_ctrl.sv
// Bench for cache_dm_ctrl: directed vector table, reset/abort corner sequences, and random
// traffic checked against a flat-memory view of the CPU address space plus a line directory.
module tb_cache_dm_ctrl;
    import cache_parameters::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cpu_req_valid = 1'b0;
    logic            cpu_req_rw = 1'b0;
    logic [15:0]     cpu_req_addr = '0;
    logic [31:0]     cpu_req_data = '0;
    logic            cpu_req_ready;
    logic            cpu_res_ready;
    logic [31:0]     cpu_res_data;
    memory_request_t  mem_req;
    memory_response_t mem_res;

    always #5 clk = ~clk;

    cache_dm_ctrl #(.INDEX_WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_rw    (cpu_req_rw),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_data  (cpu_req_data),
        .cpu_req_ready (cpu_req_ready),
        .cpu_res_ready (cpu_res_ready),
        .cpu_res_data  (cpu_res_data),
        .mem_req       (mem_req),
        .mem_res       (mem_res)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing memory (what RAM holds) and the CPU-visible memory (what a read must return).
    logic [31:0] mem    [65536];
    logic [31:0] shadow [65536];

    // Line directory of the reference model.
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [9:0]  m_tag   [16];

    typedef struct {
        bit          rw;
        logic [15:0] addr;
        block_t      data;
    } tx_t;
    tx_t tx_q[$];
    tx_t tx_rec;

    int lat_min   = 0;
    int lat_max   = 3;
    int rlat      = 0;
    int rcnt      = 0;
    bit ack_real  = 0;
    bit ack_noise = 1;
    bit cs_prev   = 0;
    int cs_rises  = 0;
    logic [15:0] ra;

    // Behavioural RAM: one-cycle ack after a random wait, stray acks while cs is low.
    initial begin
        mem_res = '0;
        forever begin
            @(negedge clk);
            if (mem_req.cs && !cs_prev) cs_rises++;
            cs_prev = mem_req.cs;
            if (ack_real) begin
                mem_res.ack = 1'b0;
                ack_real    = 0;
                rcnt        = 0;
                rlat        = $urandom_range(lat_max, lat_min);
            end else if (mem_req.cs) begin
                mem_res.ack = 1'b0;
                if (rcnt >= rlat) begin
                    tx_rec.rw   = mem_req.rw;
                    tx_rec.addr = mem_req.addr;
                    tx_rec.data = mem_req.data;
                    tx_q.push_back(tx_rec);
                    for (int w = 0; w < 4; w++) begin
                        ra = mem_req.addr + 16'(w);
                        if (mem_req.rw) mem[ra] = mem_req.data[w];
                        else            mem_res.data[w] = mem[ra];
                    end
                    mem_res.ack = 1'b1;
                    ack_real    = 1;
                end else begin
                    rcnt++;
                end
            end else begin
                rcnt         = 0;
                mem_res.ack  = ack_noise && ($urandom_range(3, 0) == 0);
                mem_res.data = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cpu_req_valid = 1'b0;
        #1;
        chk("rst_cs_low", mem_req.cs, 0);
        chk("rst_res_ready_low", cpu_res_ready, 0);
        chk("rst_req_ready_high", cpu_req_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        for (int a = 0; a < 65536; a++) shadow[16'(a)] = mem[16'(a)];
        @(negedge clk);
        chk("post_rst_cs", mem_req.cs, 0);
        chk("post_rst_res_ready", cpu_res_ready, 0);
        chk("post_rst_req_ready", cpu_req_ready, 1);
    endtask

    task automatic do_req(input bit rw, input logic [15:0] addr, input logic [31:0] wdata,
                          input bit noise, output logic [31:0] rdata, output int lat,
                          output int ntx);
        logic [3:0]  idx;
        logic [9:0]  tag;
        logic [15:0] old_base;
        logic [15:0] new_base;
        bit exp_hit, exp_wb, got, busy_bad;
        int guard;
        idx      = addr[5:2];
        tag      = addr[15:6];
        exp_hit  = m_valid[idx] && (m_tag[idx] == tag);
        exp_wb   = !exp_hit && m_valid[idx] && m_dirty[idx];
        old_base = {m_tag[idx], idx, 2'b00};
        new_base = {tag, idx, 2'b00};
        rdata    = '0;
        guard    = 0;
        while (!cpu_req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_before_req", cpu_req_ready, 1);
        tx_q.delete();
        cs_rises      = 0;
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        cpu_req_data  = wdata;
        lat      = 0;
        got      = 0;
        busy_bad = 0;
        while (!got && lat < 500) begin
            @(negedge clk);
            lat++;
            if (cpu_res_ready) begin
                got           = 1;
                rdata         = cpu_res_data;
                cpu_req_valid = 1'b0;
                chk("res_cs_low", mem_req.cs, 0);
                chk("res_mem_rw_zero", mem_req.rw, 0);
                chk("res_mem_addr_zero", mem_req.addr, 0);
                chk("res_mem_data_zero", (mem_req.data == '0), 1);
            end else begin
                if (cpu_req_ready) busy_bad = 1;
                if (noise) begin
                    cpu_req_valid = lat[0];
                    cpu_req_rw    = 1'($urandom);
                    cpu_req_addr  = 16'($urandom);
                    cpu_req_data  = $urandom;
                end else begin
                    cpu_req_valid = 1'b0;
                end
            end
        end
        cpu_req_valid = 1'b0;
        chk("res_within_budget", got, 1);
        chk("req_ready_low_while_busy", busy_bad, 0);
        @(negedge clk);
        chk("res_single_pulse", cpu_res_ready, 0);
        chk("res_data_zero_idle", cpu_res_data, 0);
        chk("req_ready_back", cpu_req_ready, 1);
        ntx = tx_q.size();
        if (exp_hit) begin
            chk("hit_latency", lat, 1);
            chk("hit_no_mem_tx", ntx, 0);
        end else begin
            chk("miss_tx_count", ntx, exp_wb ? 2 : 1);
            chk("miss_cs_single_burst", cs_rises, 1);
            if (exp_wb && ntx == 2) begin
                chk("wb_rw", tx_q[0].rw, 1);
                chk("wb_addr", tx_q[0].addr, old_base);
                for (int w = 0; w < 4; w++)
                    chk("wb_data", tx_q[0].data[w], shadow[old_base + 16'(w)]);
                chk("alloc_rw", tx_q[1].rw, 0);
                chk("alloc_addr", tx_q[1].addr, new_base);
            end else if (!exp_wb && ntx == 1) begin
                chk("alloc_rw", tx_q[0].rw, 0);
                chk("alloc_addr", tx_q[0].addr, new_base);
            end
        end
        if (!rw) chk("read_data", rdata, shadow[addr]);
        if (rw) shadow[addr] = wdata;
        m_dirty[idx] = exp_hit ? (m_dirty[idx] | rw) : rw;
        m_valid[idx] = 1;
        m_tag[idx]   = tag;
    endtask

    typedef struct {
        bit          rw;
        logic [15:0] addr;
        logic [31:0] wdata;
        bit          chk_data;
        logic [31:0] exp_data;
        int          exp_ntx;
        int          exp_lat;
        bit          chk_wb;
        block_t      exp_wb_data;
    } vec_t;
    vec_t vecs[6];

    localparam logic [31:0] A0 = 32'hA0A0_0000;
    localparam logic [31:0] A1 = 32'hA1A1_0001;
    localparam logic [31:0] A2 = 32'hA2A2_0002;
    localparam logic [31:0] A3 = 32'hA3A3_0003;

    logic [31:0] rd;
    int          lat, ntx;
    bit          cs_seen;
    logic [31:0] mem_0086;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[16'(a)] = $urandom;
        mem[16'h0044] = A0;
        mem[16'h0045] = A1;
        mem[16'h0046] = A2;
        mem[16'h0047] = A3;
        mem_0086 = mem[16'h0086];

        //            rw  addr      wdata          chk exp_data      ntx lat wb  wb data
        vecs[0] = '{1'b0, 16'h0045, 32'h0,         1, A1,            1,  0, 0, '0};
        vecs[1] = '{1'b1, 16'h0046, 32'hDEADBEEF,  0, 32'h0,         0,  1, 0, '0};
        vecs[2] = '{1'b0, 16'h0046, 32'h0,         1, 32'hDEADBEEF,  0,  1, 0, '0};
        vecs[3] = '{1'b0, 16'h0086, 32'h0,         1, mem_0086,      2,  0, 1,
                    {A3, 32'hDEADBEEF, A1, A0}};
        vecs[4] = '{1'b0, 16'h0045, 32'h0,         1, A1,            1,  0, 0, '0};
        vecs[5] = '{1'b0, 16'h0046, 32'h0,         1, 32'hDEADBEEF,  0,  1, 0, '0};

        do_reset();

        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 1'b0, rd, lat, ntx);
            if (vecs[i].chk_data) chk("vec_data", rd, vecs[i].exp_data);
            chk("vec_ntx", ntx, vecs[i].exp_ntx);
            if (vecs[i].exp_lat != 0) chk("vec_latency", lat, vecs[i].exp_lat);
            if (vecs[i].chk_wb && ntx > 0) begin
                chk("vec_wb_addr", tx_q[0].addr, 16'h0044);
                for (int w = 0; w < 4; w++)
                    chk("vec_wb_data", tx_q[0].data[w], vecs[i].exp_wb_data[w]);
            end
        end
        chk("mem_0046_written_back", mem[16'h0046], 32'hDEADBEEF);

        // Reset in the middle of a slow ALLOCATE.
        lat_min = 20;
        lat_max = 20;
        rlat    = 20;
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = 16'h0100;
        cs_seen = 0;
        for (int c = 0; c < 10 && !cs_seen; c++) begin
            @(negedge clk);
            cpu_req_valid = 1'b0;
            if (mem_req.cs) cs_seen = 1;
        end
        chk("abort_alloc_reached", cs_seen, 1);
        chk("abort_alloc_addr", mem_req.addr, 16'h0100);
        do_reset();
        lat_min = 0;
        lat_max = 3;
        do_req(1'b0, 16'h0100, 32'h0, 1'b0, rd, lat, ntx);
        chk("abort_reread_misses", ntx, 1);

        // Request strobes during a long ALLOCATE must be ignored.
        lat_min = 8;
        lat_max = 8;
        rlat    = 8;
        do_req(1'b0, 16'h0200, 32'h0, 1'b1, rd, lat, ntx);
        chk("busy_strobe_single_alloc", ntx, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("busy_strobe_no_extra_res", cpu_res_ready, 0);
        end
        lat_min = 0;
        lat_max = 3;

        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            a = {8'h00, 2'($urandom_range(3, 0)), 4'($urandom), 2'($urandom)};
            do_req(1'($urandom), a, $urandom, 1'b1, rd, lat, ntx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
